dbg_trace_wb: RTL and testbench
===============================

# dbg_trace_wb

Wishbone-slave debug controller for the user project: replaces the logic-analyzer-driven debug control bits with a memory-mapped control word. It adds a parametrised trace buffer that captures core status samples (DSBF, ARC timing, CTC state) with trigger and post-trigger stop. It sits beside the calculator core inside the user project wrapper, on the Caravel Wishbone bus.

## Interface
Parameters:
- DW, 32: trace sample width, 1..32; narrower samples read zero-extended.
- DEPTH, 64: trace entries, power of two, 4..256.
- BASE_ADR, 32'h3000_0000: decode base; block owns BASE_ADR[31:8] window.
- DBG_RST, 32'h0: reset value of dbg_ctrl_o.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rstn_i  in  1  reset; synchronous, active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- trc_valid_i  in  1  sample strobe from core.
- trc_data_i  in  DW  sample.
- trig_i  in  1  trigger level from core.
- dbg_ctrl_o  out  32  debug control word to core.
- irq_o  out  1  capture-done interrupt, level.

## Operation
- Decode hit: cyc & stb & adr[31:8]==BASE_ADR[31:8]. Misses: no ack, dat 0.
- Registers (adr[4:2]): 0 CTRL rw: [0] EN, [1] MODE (0 stop-on-full, 1 wrap), [2] ARM, [3] CLR (self-clearing, reads 0). 1 STATUS ro: [0] empty, [1] full, [2] triggered, [3] overflow (sticky), [4] done, [24:16] count. 2 DATA ro: read pops head; empty read returns 0, no pointer change. 3 DBG rw: dbg_ctrl_o, byte-lane writes per sel. 4 POSTTRIG rw [8:0]: samples captured after trigger. 5 TSTAMP ro (see Configuration). 6,7 read 0, writes ignored.
- Capture: trc_valid_i & EN & !done pushes trc_data_i.
- MODE 0 full: sample dropped, overflow set. MODE 1 full: oldest entry discarded (head advances), sample written, overflow set.
- Push and pop same cycle: both performed, count unchanged. Full with push and pop: no discard.
- Trigger: while ARM & EN & !triggered, trig_i=1 sets triggered and loads post counter from POSTTRIG. Each later push decrements it. At zero, done=1 and capture stops. POSTTRIG=0 stops on the trigger cycle; the trigger-cycle sample is still pushed.
- Without ARM, MODE 0 sets done on reaching full; MODE 1 never sets done.
- irq_o = done. CLR clears pointers, count, triggered, overflow, done in one cycle. A write setting EN from 0 also clears done.
- CLR and a push in the same cycle: CLR wins, sample dropped.

## Timing
- Reset: wbs_ack_o 0, wbs_dat_o 0, dbg_ctrl_o DBG_RST, irq_o 0, CTRL 0, POSTTRIG 0, FIFO empty, all flags 0.
- Ack is registered: asserts the cycle after a hit, for exactly one cycle. It is not reasserted while ack is high, so back-to-back transfers take 2 cycles each.
- Read data is valid with ack. A DATA pop takes effect on the ack cycle. A write takes effect on the ack cycle; dbg_ctrl_o updates the following cycle.
- Push visible in count 1 cycle after trc_valid_i. trig_i is sampled registered, with 1 cycle latency to triggered.
- Reset asserted mid-transfer aborts it; no ack is issued.

## Configuration
- DBG_TRACE_TIMESTAMP_EN defined: 16-bit free-running cycle counter, reset 0, wraps. Each entry stores the counter value at push. A DATA pop latches that entry's timestamp into TSTAMP[15:0].
- Undefined: no counter or timestamp storage; TSTAMP reads 0.

## Structure
- Package dbg_trace_pkg: register offset constants, CTRL/STATUS bit indices, count-width function clog2(DEPTH)+1.
- Sub-module dbg_trace_fifo: storage, head/tail/count, wrap-discard and simultaneous push/pop logic. The top holds the Wishbone decode, registers and trigger FSM (IDLE, ARMED, POST, DONE).

## Test plan
- Reset, then read all registers -> STATUS 0x1 (empty), DBG = DBG_RST, other registers 0, irq_o 0.
- DEPTH=4, MODE 0, push 6 samples 1..6 -> count 4, full, overflow, done, irq_o 1; pops return 1,2,3,4, then 0.
- MODE 1, push 1..6 -> pops return 3,4,5,6; overflow 1, done 0.
- ARM, POSTTRIG=2, trig_i pulsed at sample 10 of stream 1..20 -> FIFO holds ..10,11,12, done 1, sample 13 not stored.
- Full FIFO, pop and push in the same cycle -> count stays DEPTH, no overflow change, order preserved.
- Write DBG 0xA5A5_A5A5 with sel=4'b0010 from 0 -> dbg_ctrl_o 0x0000_A500; an access outside the BASE_ADR window -> no ack.

Source files
------------

// File: rtl/dbg_trace_pkg.sv
// Shared register map, bit positions and trigger states for the dbg_trace Wishbone debug block.
// The optional timestamp feature is enabled by defining DBG_TRACE_TIMESTAMP_EN.
package dbg_trace_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_DATA     = 3'd2;
  localparam logic [2:0] REG_DBG      = 3'd3;
  localparam logic [2:0] REG_POSTTRIG = 3'd4;
  localparam logic [2:0] REG_TSTAMP   = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_ARM  = 2;
  localparam int CTRL_CLR  = 3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_TRIG    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_CNT_LSB = 16;

  localparam int TS_W = 16;

  typedef enum logic [1:0] {
    TRIG_IDLE,
    TRIG_ARMED,
    TRIG_POST,
    TRIG_DONE
  } trig_state_e;

  // Count needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Trace storage: circular buffer with head/tail/count, wrap-mode discard of the oldest
// entry and simultaneous push/pop. Callers pre-qualify push (enable, done, clear).
module dbg_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             wrap,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_pop;
  logic             do_write;
  logic             discard;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[head];

  // A pop in the same cycle frees a slot, so a full FIFO then neither drops nor discards.
  always_comb begin
    do_pop   = pop & ~empty;
    do_write = push & (~full | do_pop | wrap);
    discard  = push & full & ~do_pop & wrap;
    ovf      = push & full & ~do_pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_write) tail <= tail + AW'(1);
      if (do_pop || discard) head <= head + AW'(1);
      if (do_write && !discard && !do_pop) count <= count + CW'(1);
      else if (do_pop && !do_write) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[tail] <= wdata;
  end

endmodule

// File: rtl/dbg_trace_wb.sv
// Wishbone-slave debug controller: control word register, trace buffer and trigger FSM.
// Define DBG_TRACE_TIMESTAMP_EN to store a 16-bit cycle timestamp with every trace entry.
module dbg_trace_wb
  import dbg_trace_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          DEPTH    = 64,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] DBG_RST  = 32'h0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rstn_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          trc_valid_i,
  input  logic [DW-1:0] trc_data_i,
  input  logic          trig_i,
  output logic [31:0]   dbg_ctrl_o,
  output logic          irq_o
);

  localparam int CW = cnt_width(DEPTH);
`ifdef DBG_TRACE_TIMESTAMP_EN
  localparam int FW = DW + TS_W;
`else
  localparam int FW = DW;
`endif

  logic          hit, access, wr_en, rd_en;
  logic [2:0]    reg_sel;
  logic          wr_ctrl, wr_dbg, wr_post, rd_data, clr, en_rise;
  logic          ctrl_en, ctrl_mode, ctrl_arm;
  logic [31:0]   dbg_q;
  logic [8:0]    posttrig_q, post_cnt, post_n;
  logic          triggered, trig_n, ovf_q, done, push_req;
  trig_state_e   state, state_n;
  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, fifo_ovf;
  logic [31:0]   rdata;
  logic [15:0]   ts_q;
  logic          unused_adr;

  assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  // A hit is accepted only while ack is low, giving one ack per transfer.
  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign access  = hit & ~wbs_ack_o;
  assign wr_en   = access & wbs_we_i;
  assign rd_en   = access & ~wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];
  assign wr_ctrl = wr_en & (reg_sel == REG_CTRL);
  assign wr_dbg  = wr_en & (reg_sel == REG_DBG);
  assign wr_post = wr_en & (reg_sel == REG_POSTTRIG);
  assign rd_data = rd_en & (reg_sel == REG_DATA);
  assign clr     = wr_ctrl & wbs_dat_i[CTRL_CLR];
  assign en_rise = wr_ctrl & wbs_dat_i[CTRL_EN] & ~ctrl_en;

  assign done     = (state == TRIG_DONE);
  assign irq_o    = done;
  assign push_req = trc_valid_i & ctrl_en & ~done & ~clr;

`ifdef DBG_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (rd_data && !fifo_empty) ts_q <= fifo_rdata[FW-1 -: TS_W];
    end
  end

  assign fifo_wdata = {ts_cnt, trc_data_i};
`else
  assign ts_q       = '0;
  assign fifo_wdata = trc_data_i;
`endif

  dbg_trace_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .clr   (clr),
    .push  (push_req),
    .pop   (rd_data),
    .wrap  (ctrl_mode),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .ovf   (fifo_ovf)
  );

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]   = ctrl_en;
        rdata[CTRL_MODE] = ctrl_mode;
        rdata[CTRL_ARM]  = ctrl_arm;
      end
      REG_STATUS: begin
        rdata[STAT_EMPTY]           = fifo_empty;
        rdata[STAT_FULL]            = fifo_full;
        rdata[STAT_TRIG]            = triggered;
        rdata[STAT_OVF]             = ovf_q;
        rdata[STAT_DONE]            = done;
        rdata[STAT_CNT_LSB +: 9]    = 9'(fifo_count);
      end
      REG_DATA:     if (!fifo_empty) rdata = 32'(fifo_rdata[DW-1:0]);
      REG_DBG:      rdata = dbg_q;
      REG_POSTTRIG: rdata[8:0] = posttrig_q;
      REG_TSTAMP:   rdata[15:0] = ts_q;
      default:      rdata = '0;
    endcase
  end

  // dbg_ctrl_o trails the DBG register by one cycle so the core sees a clean registered copy.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ctrl_en    <= 1'b0;
      ctrl_mode  <= 1'b0;
      ctrl_arm   <= 1'b0;
      posttrig_q <= '0;
      dbg_q      <= DBG_RST;
      dbg_ctrl_o <= DBG_RST;
      ovf_q      <= 1'b0;
    end else begin
      wbs_ack_o  <= access;
      wbs_dat_o  <= rd_en ? rdata : '0;
      dbg_ctrl_o <= dbg_q;
      if (wr_ctrl) begin
        ctrl_en   <= wbs_dat_i[CTRL_EN];
        ctrl_mode <= wbs_dat_i[CTRL_MODE];
        ctrl_arm  <= wbs_dat_i[CTRL_ARM];
      end
      if (wr_post) posttrig_q <= wbs_dat_i[8:0];
      if (wr_dbg) begin
        for (int i = 0; i < 4; i++) begin
          if (wbs_sel_i[i]) dbg_q[8*i +: 8] <= wbs_dat_i[8*i +: 8];
        end
      end
      if (clr) ovf_q <= 1'b0;
      else if (fifo_ovf) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state     <= TRIG_IDLE;
      post_cnt  <= '0;
      triggered <= 1'b0;
    end else begin
      state     <= state_n;
      post_cnt  <= post_n;
      triggered <= trig_n;
    end
  end

  // The trigger-cycle sample is pushed before the post counter starts counting later pushes.
  always_comb begin
    state_n = state;
    post_n  = post_cnt;
    trig_n  = triggered;
    if (clr) begin
      state_n = TRIG_IDLE;
      post_n  = '0;
      trig_n  = 1'b0;
    end else begin
      case (state)
        TRIG_IDLE, TRIG_ARMED: begin
          if (ctrl_arm && ctrl_en && !triggered) begin
            state_n = TRIG_ARMED;
            if (trig_i) begin
              trig_n  = 1'b1;
              post_n  = posttrig_q;
              state_n = (posttrig_q == '0) ? TRIG_DONE : TRIG_POST;
            end
          end else begin
            state_n = TRIG_IDLE;
            if (ctrl_en && !ctrl_arm && !ctrl_mode && fifo_full) state_n = TRIG_DONE;
          end
        end
        TRIG_POST: begin
          if (push_req) begin
            post_n = post_cnt - 9'd1;
            if (post_cnt == 9'd1) state_n = TRIG_DONE;
          end
        end
        TRIG_DONE: if (en_rise) state_n = TRIG_IDLE;
        default:   state_n = TRIG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_trace_wb.sv
// Self-checking bench for dbg_trace_wb (DEPTH=4, DW=16): directed scenarios plus a
// randomized wrap-mode phase checked against a queue-based reference model.
module tb_dbg_trace_wb;

  localparam int          DW      = 16;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [31:0] DBG_RST = 32'hC3C3_0081;

  localparam logic [2:0] O_CTRL = 3'd0, O_STATUS = 3'd1, O_DATA = 3'd2, O_DBG = 3'd3;
  localparam logic [2:0] O_POST = 3'd4, O_TS = 3'd5, O_R6 = 3'd6, O_R7 = 3'd7;

  logic          wb_clk_i = 1'b0;
  logic          wb_rstn_i = 1'b0;
  logic          wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          trc_valid_i = 1'b0;
  logic [DW-1:0] trc_data_i = '0;
  logic          trig_i = 1'b0;
  logic [31:0]   dbg_ctrl_o;
  logic          irq_o;

  int compared = 0;
  int mismatched = 0;

  dbg_trace_wb #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .BASE_ADR (BASE),
    .DBG_RST  (DBG_RST)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rstn_i   (wb_rstn_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .trc_valid_i (trc_valid_i),
    .trc_data_i  (trc_data_i),
    .trig_i      (trig_i),
    .dbg_ctrl_o  (dbg_ctrl_o),
    .irq_o       (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit trg, input bit dn);
    logic [31:0] w;
    w    = 32'(cnt) << 16;
    w[0] = (cnt == 0);
    w[1] = (cnt == DEPTH);
    w[2] = trg;
    w[3] = ovf;
    w[4] = dn;
    return w;
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    int n;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    acked = 1'b0; rdat = '0; n = 0;
    while (!acked && n < 8) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
      n++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    logic a;
    wb_xfer(1'b1, BASE | {27'd0, off, 2'b00}, dat, sel, r, a);
    check_output("wr_ack", {31'd0, a}, 32'd1);
  endtask

  task automatic wb_read_val(input logic [2:0] off, output logic [31:0] r);
    logic a;
    wb_xfer(1'b0, BASE | {27'd0, off, 2'b00}, '0, 4'hF, r, a);
    check_output("rd_ack", {31'd0, a}, 32'd1);
  endtask

  task automatic wb_read(input logic [2:0] off, input string tag, input logic [31:0] exp);
    logic [31:0] r;
    wb_read_val(off, r);
    check_output(tag, r, exp);
  endtask

  // Streams consecutive sample values back-to-back; trig_i accompanies the value trig_at.
  task automatic apply_stimulus(input int first, input int n, input int trig_at);
    for (int i = 0; i < n; i++) begin
      @(negedge wb_clk_i);
      trc_valid_i = 1'b1;
      trc_data_i  = DW'(first + i);
      trig_i      = (first + i == trig_at);
    end
    @(negedge wb_clk_i);
    trc_valid_i = 1'b0;
    trig_i      = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    int          model_q[$];
    bit          model_ovf;
    int          n, k, d;

    $display("[TB] reset");
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);
    check_output("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check_output("rst_dat", wbs_dat_o, 32'd0);
    check_output("rst_dbg_out", dbg_ctrl_o, DBG_RST);
    check_output("rst_irq", {31'd0, irq_o}, 32'd0);
    wb_read(O_CTRL,   "rst_ctrl",   32'd0);
    wb_read(O_STATUS, "rst_status", 32'h1);
    wb_read(O_DATA,   "rst_data",   32'd0);
    wb_read(O_DBG,    "rst_dbg",    DBG_RST);
    wb_read(O_POST,   "rst_post",   32'd0);
    wb_read(O_TS,     "rst_ts",     32'd0);
    wb_read(O_R6,     "rst_r6",     32'd0);
    wb_read(O_R7,     "rst_r7",     32'd0);

    $display("[TB] stop-on-full");
    wb_write(O_CTRL, 32'h1, 4'hF);
    apply_stimulus(1, 6, 0);
    check_output("m0_irq", {31'd0, irq_o}, 32'd1);
    wb_read(O_STATUS, "m0_status", status_word(4, 1, 0, 1));
    for (int i = 1; i <= 4; i++) wb_read(O_DATA, "m0_pop", 32'(i));
    wb_read(O_DATA, "m0_pop_empty", 32'd0);
    wb_read(O_STATUS, "m0_status_after", status_word(0, 1, 0, 1));

    $display("[TB] wrap");
    wb_write(O_CTRL, 32'hB, 4'hF);
    wb_read(O_STATUS, "clr_status", 32'h1);
    check_output("clr_irq", {31'd0, irq_o}, 32'd0);
    apply_stimulus(1, 6, 0);
    wb_read(O_STATUS, "m1_status", status_word(4, 1, 0, 0));
    for (int i = 3; i <= 6; i++) wb_read(O_DATA, "m1_pop", 32'(i));
    check_output("m1_irq", {31'd0, irq_o}, 32'd0);

    $display("[TB] trigger");
    wb_write(O_POST, 32'd2, 4'hF);
    wb_read(O_POST, "post_rb", 32'd2);
    wb_write(O_CTRL, 32'hF, 4'hF);
    wb_read(O_CTRL, "ctrl_rb", 32'h7);
    apply_stimulus(1, 20, 10);
    check_output("trig_irq", {31'd0, irq_o}, 32'd1);
    wb_read(O_STATUS, "trig_status", status_word(4, 1, 1, 1));
    for (int i = 9; i <= 12; i++) wb_read(O_DATA, "trig_pop", 32'(i));
    wb_read(O_DATA, "trig_pop_empty", 32'd0);

    $display("[TB] full push+pop");
    wb_write(O_CTRL, 32'hB, 4'hF);
    apply_stimulus(1, 4, 0);
    wb_read(O_STATUS, "pp_status_pre", status_word(4, 0, 0, 0));
    repeat (2) @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE | {27'd0, O_DATA, 2'b00};
    trc_valid_i = 1'b1; trc_data_i = DW'(5);
    @(posedge wb_clk_i); #1;
    check_output("pp_ack", {31'd0, wbs_ack_o}, 32'd1);
    check_output("pp_data", wbs_dat_o, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; trc_valid_i = 1'b0;
    wb_read(O_STATUS, "pp_status_post", status_word(4, 0, 0, 0));
    for (int i = 2; i <= 5; i++) wb_read(O_DATA, "pp_pop", 32'(i));

    $display("[TB] dbg byte lanes and decode");
    wb_write(O_DBG, 32'h0, 4'hF);
    wb_write(O_DBG, 32'hA5A5_A5A5, 4'b0010);
    repeat (2) @(negedge wb_clk_i);
    check_output("dbg_out", dbg_ctrl_o, 32'h0000_A500);
    wb_read(O_DBG, "dbg_rb", 32'h0000_A500);
    wb_xfer(1'b1, BASE + 32'h0000_010C, 32'hFFFF_FFFF, 4'hF, r, a);
    check_output("miss_ack", {31'd0, a}, 32'd0);
    check_output("miss_dat", r, 32'd0);
    wb_read(O_DBG, "miss_no_write", 32'h0000_A500);

    $display("[TB] reset mid-transfer");
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE | {27'd0, O_DBG, 2'b00};
    wb_rstn_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check_output("abort_ack", {31'd0, wbs_ack_o}, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);
    check_output("abort_dbg_out", dbg_ctrl_o, DBG_RST);
    wb_read(O_STATUS, "abort_status", 32'h1);

    $display("[TB] randomized wrap traffic");
    wb_write(O_CTRL, 32'hB, 4'hF);
    model_ovf = 1'b0;
    for (int round = 0; round < 12; round++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        @(negedge wb_clk_i);
        trc_valid_i = ($urandom_range(0, 3) != 0);
        d = int'($urandom_range(0, 16'hFFFF));
        trc_data_i = DW'(d);
        if (trc_valid_i) begin
          if (model_q.size() == DEPTH) begin
            void'(model_q.pop_front());
            model_ovf = 1'b1;
          end
          model_q.push_back(d);
        end
      end
      @(negedge wb_clk_i);
      trc_valid_i = 1'b0;
      wb_read(O_STATUS, "rnd_status", status_word(model_q.size(), model_ovf, 0, 0));
      k = $urandom_range(0, model_q.size() + 1);
      for (int j = 0; j < k; j++) begin
        wb_read_val(O_DATA, r);
        if (model_q.size() > 0) check_output("rnd_pop", r, 32'(model_q.pop_front()));
        else check_output("rnd_pop_empty", r, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
